count_sequencer: RTL and testbench

//  Stimulus master for the dual-mode event counter. Drives its Slt/En/Reset inputs so its

---
 rtl/count_sequencer_pkg.sv | 19 +
 rtl/count_sequencer_dcnt.sv | 31 +++
 rtl/count_sequencer.sv | 132 +++++++++++++
 tb/tb_count_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/count_sequencer_pkg.sv
// count_sequencer_pkg: state encoding and DIV shift helper
// shared by count_sequencer and count_sequencer_dcnt
package count_sequencer_pkg;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CLR  = 3'd1;
  localparam logic [2:0] RUN0 = 3'd2;
  localparam logic [2:0] RUN1 = 3'd3;
  localparam logic [2:0] FIN  = 3'd4;

  // DIV is a power of two, so this is an exact log2
  function automatic int div_log2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/count_sequencer_dcnt.sv
// count_sequencer_dcnt: loadable down-counter, zero/last flags
// ports: clk, rst_n, load/value, en, hold -> zero, last
module count_sequencer_dcnt #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  input  logic         hold,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en && !hold && !zero) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);
  assign last = (count == W'(1));

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: drives Slt/En/Reset of the dual-mode counter
// ports: Clk, Reset, Start/ClrFirst/Hold/Target* -> Busy/Done/RstOut/EnOut/SltOut
module count_sequencer
  import count_sequencer_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DIV   = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             ClrFirst,
  input  logic             Hold,
  input  logic [WIDTH-1:0] Target0,
  input  logic [WIDTH-1:0] Target1,
  output logic             Busy,
  output logic             Done,
  output logic             RstOut,
  output logic             EnOut,
  output logic             SltOut
);

  localparam int SH = div_log2(DIV);
  localparam int W1 = WIDTH + SH;

  logic [2:0]    state;
  logic [2:0]    nxt;
  logic          t0_nz;
  logic          t1_nz;
  logic          run;
  logic          load;
  logic          zero0;
  logic          last0;
  logic          zero1;
  logic          last1;
  logic          end0;
  logic          end1;
  logic [W1-1:0] value1;

  assign load   = (state == IDLE) && Start;
  assign value1 = W1'(Target1) << SH;

  count_sequencer_dcnt #(
    .W(WIDTH)
  ) u_rem0 (
    .clk   (Clk),
    .rst_n (Reset),
    .load  (load),
    .value (Target0),
    .en    (state == RUN0),
    .hold  (Hold),
    .zero  (zero0),
    .last  (last0)
  );

  count_sequencer_dcnt #(
    .W(W1)
  ) u_rem1 (
    .clk   (Clk),
    .rst_n (Reset),
    .load  (load),
    .value (value1),
    .en    (state == RUN1),
    .hold  (Hold),
    .zero  (zero1),
    .last  (last1)
  );

  // the enable issued this cycle is the final one
  assign end0 = !Hold && (last0 || zero0);
  assign end1 = !Hold && (last1 || zero1);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      t0_nz <= 1'b0;
      t1_nz <= 1'b0;
    end else if (load) begin
      t0_nz <= (Target0 != '0);
      t1_nz <= (Target1 != '0);
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (Start) begin
          if (ClrFirst)             nxt = CLR;
          else if (Target0 != '0)   nxt = RUN0;
          else if (Target1 != '0)   nxt = RUN1;
          else                      nxt = FIN;
        end
      end
      CLR: begin
        if (t0_nz)      nxt = RUN0;
        else if (t1_nz) nxt = RUN1;
        else            nxt = FIN;
      end
      RUN0: begin
        if (end0) nxt = t1_nz ? RUN1 : FIN;
      end
      RUN1: begin
        if (end1) nxt = FIN;
      end
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // output flops are decoded from the next state so they
  // line up with the state register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      RstOut <= 1'b0;
      SltOut <= 1'b0;
      run    <= 1'b0;
    end else begin
      state  <= nxt;
      Busy   <= (nxt == CLR) || (nxt == RUN0) || (nxt == RUN1);
      Done   <= (nxt == FIN);
      RstOut <= (nxt == CLR);
      SltOut <= (nxt == RUN1);
      run    <= (nxt == RUN0) || (nxt == RUN1);
    end
  end

  assign EnOut = run && !Hold;

endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: directed bench with downstream counter model
// checks handshake latency, enable counts and counter outputs
module tb_count_sequencer;

  localparam int WIDTH = 64;
  localparam int DIV   = 4;

  logic             Clk = 1'b0;
  logic             Reset = 1'b0;
  logic             Start = 1'b0;
  logic             ClrFirst = 1'b0;
  logic             Hold = 1'b0;
  logic [WIDTH-1:0] Target0 = '0;
  logic [WIDTH-1:0] Target1 = '0;
  logic             Busy;
  logic             Done;
  logic             RstOut;
  logic             EnOut;
  logic             SltOut;

  logic [63:0] out0 = '0;
  logic [63:0] cnt1 = '0;
  logic [63:0] out1;

  int errors = 0;
  int checks = 0;
  int dlat;
  int ens;
  int slt;
  int rst_at;
  int first_en;
  int busy_bad;

  count_sequencer #(
    .WIDTH (WIDTH),
    .DIV   (DIV)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .ClrFirst (ClrFirst),
    .Hold     (Hold),
    .Target0  (Target0),
    .Target1  (Target1),
    .Busy     (Busy),
    .Done     (Done),
    .RstOut   (RstOut),
    .EnOut    (EnOut),
    .SltOut   (SltOut)
  );

  always #5 Clk = ~Clk;

  // downstream dual-mode counter: no reset of its own
  always @(posedge Clk) begin
    if (RstOut) begin
      out0 <= '0;
      cnt1 <= '0;
    end else if (EnOut) begin
      if (SltOut) cnt1 <= cnt1 + 64'd1;
      else        out0 <= out0 + 64'd1;
    end
  end

  assign out1 = cnt1 / DIV;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one transaction; cycle numbers are relative to the Start edge
  task automatic run(input logic [63:0] t0,
                     input logic [63:0] t1,
                     input logic        clr,
                     input int          hold_at,
                     input int          hold_len,
                     input int          restart_at);
    @(posedge Clk); #1;
    Target0  = t0;
    Target1  = t1;
    ClrFirst = clr;
    Start    = 1'b1;
    @(posedge Clk); #1;
    Start    = 1'b0;
    dlat     = -1;
    ens      = 0;
    slt      = 0;
    rst_at   = -1;
    first_en = -1;
    busy_bad = 0;
    for (int c = 1; c < 400; c++) begin
      Hold = (c >= hold_at) && (c < hold_at + hold_len);
      Start = (c == restart_at);
      if (c == restart_at) Target0 = 64'd3;
      #1;
      if (Done) begin
        dlat = c;
        break;
      end
      if (EnOut) begin
        ens++;
        if (first_en < 0) first_en = c;
      end
      if (SltOut) slt++;
      if (RstOut && rst_at < 0) rst_at = c;
      if (!Busy) busy_bad++;
      @(posedge Clk); #1;
    end
    Hold  = 1'b0;
    Start = 1'b0;
  endtask

  initial begin
    #2;
    check("reset_outs", {Busy, Done, RstOut, EnOut, SltOut}, 5'b0);
    #20;
    Reset = 1'b1;

    run(64'd5, 64'd0, 1'b0, 0, 0, 0);
    check("t1_done", dlat, 6);
    check("t1_ens", ens, 5);
    check("t1_slt", slt, 0);
    check("t1_first", first_en, 1);
    check("t1_busy", busy_bad, 0);
    check("t1_out0", out0, 5);
    check("t1_out1", out1, 0);

    run(64'd0, 64'd3, 1'b0, 0, 0, 0);
    check("t2_done", dlat, 13);
    check("t2_ens", ens, 12);
    check("t2_slt", slt, 12);
    check("t2_out1", out1, 3);
    check("t2_out0", out0, 5);

    run(64'd7, 64'd0, 1'b1, 0, 0, 0);
    check("t3_pre", out0, 7);
    run(64'd2, 64'd0, 1'b1, 0, 0, 0);
    check("t3_rst", rst_at, 1);
    check("t3_first", first_en, 2);
    check("t3_ens", ens, 2);
    check("t3_done", dlat, 4);
    check("t3_out0", out0, 2);

    run(64'd0, 64'd2, 1'b0, 4, 3, 0);
    check("t4_done", dlat, 12);
    check("t4_ens", ens, 8);
    check("t4_slt", slt, 11);
    check("t4_out1", out1, 2);

    run(64'd10, 64'd0, 1'b0, 0, 0, 3);
    check("t5_ignore_ens", ens, 10);
    check("t5_ignore_done", dlat, 11);
    @(posedge Clk); #1;
    check("t5_noqueue", Busy, 1'b0);
    check("t5_out0", out0, 12);

    Target0  = 64'd10;
    Target1  = 64'd0;
    ClrFirst = 1'b0;
    Start    = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (3) @(posedge Clk);
    #3;
    Reset = 1'b0;
    #1;
    check("t5_abort_outs", {Busy, Done, RstOut, EnOut, SltOut}, 5'b0);
    check("t5_abort_out0", out0, 15);
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #2;
    check("t5_idle", {Busy, EnOut}, 2'b0);
    check("t5_keep_out0", out0, 15);

    run(64'd0, 64'd0, 1'b0, 0, 0, 0);
    check("t6_done", dlat, 1);
    check("t6_ens", ens, 0);
    check("t6_busy", Busy, 1'b0);
    run(64'd3, 64'd0, 1'b0, 0, 0, 0);
    check("t6_b2b_done", dlat, 4);
    check("t6_b2b_ens", ens, 3);
    check("t6_b2b_out0", out0, 18);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
